// File: rtl/branch_resolver_pkg.sv
// Shared constants and types for the MicroEV20 execute-stage branch resolver.
package ev20_branch_pkg;

    localparam int unsigned INSTR_W = 14;
    localparam int unsigned PC_W    = 11;

    localparam logic [2:0] OP_JMP = 3'b100;

    localparam logic [1:0] CC_Z = 2'b01;
    localparam logic [1:0] CC_C = 2'b10;
    localparam logic [1:0] CC_N = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } br_state_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Redirect valid/ready channel from the branch resolver toward fetch.
interface branch_resolver_if;
    import ev20_branch_pkg::*;

    logic            redirect_valid;
    logic            redirect_ready;
    logic [PC_W-1:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );

endinterface

// File: rtl/branch_resolver_cond_eval.sv
// Combinational conditional-branch decode and flag evaluation.
module branch_cond_eval
    import ev20_branch_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic               flag_z,
    input  logic               flag_c,
    input  logic               flag_n,
    output logic               is_cond,
    output logic               taken
);

    logic flag_sel;
    logic unused_ok;

    // The target field is consumed by the caller, not here.
    assign unused_ok = ^instr[10:0];

    // Select the flag named by the condition code and qualify with the decode.
    always_comb begin
        is_cond  = instr[13] && (instr[13:11] != OP_JMP);
        flag_sel = 1'b0;
        case (instr[12:11])
            CC_Z:    flag_sel = flag_z;
            CC_C:    flag_sel = flag_c;
            CC_N:    flag_sel = flag_n;
            default: flag_sel = 1'b0;
        endcase
        taken = is_cond && flag_sel;
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage conditional branch resolver: evaluates branches, issues the
// fetch redirect, flushes younger stages and releases the fetch hold.
// Optional build macro BRANCH_STATS_EN adds saturating branch counters.
module branch_resolver
    import ev20_branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [INSTR_W-1:0]   ex_instr,
    input  logic [PC_W-1:0]      ex_pc,
    input  logic                 flag_z,
    input  logic                 flag_c,
    input  logic                 flag_n,
    branch_resolver_if.master    redir,
    output logic                 flush,
    output logic                 branch_done,
    output logic                 busy,
    output logic [15:0]          stat_cond,
    output logic [15:0]          stat_taken
);

    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

    br_state_t       state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            rv_q, rv_d;
    logic            flush_q, flush_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;

    logic is_cond, taken, accept, hs;
    logic unused_ok;

    assign unused_ok = ^ex_pc;

    branch_cond_eval u_cond (
        .instr   (ex_instr),
        .flag_z  (flag_z),
        .flag_c  (flag_c),
        .flag_n  (flag_n),
        .is_cond (is_cond),
        .taken   (taken)
    );

    // Only IDLE accepts; anything seen while busy is wrong-path.
    assign accept = (state_q == IDLE) && ex_valid && is_cond;
    assign hs     = (state_q == REDIRECT) && rv_q && redir.redirect_ready;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pc_q    <= '0;
            rv_q    <= 1'b0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            rv_q    <= rv_d;
            flush_q <= flush_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic, flush countdown and target latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (accept && taken) begin
                    state_d = REDIRECT;
                    pc_d    = ex_instr[PC_W-1:0];
                end
            end
            REDIRECT: begin
                if (hs) begin
                    cnt_d   = FLUSH_LD;
                    state_d = (FLUSH_CYCLES > 0) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they appear registered.
    always_comb begin
        rv_d    = (state_d == REDIRECT);
        flush_d = (state_d != IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (accept && !taken) || hs;
    end

    assign redir.redirect_valid = rv_q;
    assign redir.redirect_pc    = pc_q;
    assign flush                = flush_q;
    assign branch_done          = done_q;
    assign busy                 = busy_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_cond_q, stat_cond_d;
    logic [15:0] stat_taken_q, stat_taken_d;

    // Saturating increments on accepted / taken conditional branches.
    always_comb begin
        stat_cond_d  = stat_cond_q;
        stat_taken_d = stat_taken_q;
        if (accept && (stat_cond_q != '1))          stat_cond_d  = stat_cond_q + 16'd1;
        if (accept && taken && (stat_taken_q != '1)) stat_taken_d = stat_taken_q + 16'd1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cond_q  <= '0;
            stat_taken_q <= '0;
        end else begin
            stat_cond_q  <= stat_cond_d;
            stat_taken_q <= stat_taken_d;
        end
    end

    assign stat_cond  = stat_cond_q;
    assign stat_taken = stat_taken_q;
`else
    assign stat_cond  = '0;
    assign stat_taken = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with FLUSH_CYCLES=2.
module tb_branch_resolver;
    import ev20_branch_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               ex_valid;
    logic [INSTR_W-1:0] ex_instr;
    logic [PC_W-1:0]    ex_pc;
    logic               flag_z, flag_c, flag_n;
    logic               flush, branch_done, busy;
    logic [15:0]        stat_cond, stat_taken;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    branch_resolver_if rif ();

    branch_resolver #(.FLUSH_CYCLES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_instr    (ex_instr),
        .ex_pc       (ex_pc),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_n      (flag_n),
        .redir       (rif),
        .flush       (flush),
        .branch_done (branch_done),
        .busy        (busy),
        .stat_cond   (stat_cond),
        .stat_taken  (stat_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [13:0] instr, input logic z, input logic c, input logic n);
        ex_valid = 1'b1;
        ex_instr = instr;
        flag_z   = z;
        flag_c   = c;
        flag_n   = n;
    endtask

    task automatic outs(input string tag, input logic rv, input logic [10:0] pc,
                        input logic fl, input logic dn, input logic bz);
        chk({tag, ".rv"},    32'(rif.redirect_valid), 32'(rv));
        chk({tag, ".pc"},    32'(rif.redirect_pc),    32'(pc));
        chk({tag, ".flush"}, 32'(flush),              32'(fl));
        chk({tag, ".done"},  32'(branch_done),        32'(dn));
        chk({tag, ".busy"},  32'(busy),               32'(bz));
    endtask

    initial begin
        rst      = 1'b1;
        ex_valid = 1'b0;
        ex_instr = '0;
        ex_pc    = 11'h123;
        flag_z   = 1'b0;
        flag_c   = 1'b0;
        flag_n   = 1'b0;
        rif.redirect_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        outs("reset", 1'b0, 11'h000, 1'b0, 1'b0, 1'b0);
        chk("reset.stat_cond",  32'(stat_cond),  32'd0);
        chk("reset.stat_taken", 32'(stat_taken), 32'd0);

        // Taken Z branch, ready high: 1 REDIRECT + 2 FLUSH cycles.
        present(14'b101_00000100000, 1'b1, 1'b0, 1'b0);
        tick();
        ex_valid = 1'b0;
        outs("tz.c1", 1'b1, 11'h020, 1'b1, 1'b0, 1'b1);
        tick();
        outs("tz.c2", 1'b0, 11'h020, 1'b1, 1'b1, 1'b1);
        tick();
        outs("tz.c3", 1'b0, 11'h020, 1'b1, 1'b0, 1'b1);
        tick();
        outs("tz.c4", 1'b0, 11'h020, 1'b0, 1'b0, 1'b0);

        // Not-taken C branch (other flags high to expose mis-selection).
        present(14'b110_00000000111, 1'b1, 1'b0, 1'b1);
        tick();
        ex_valid = 1'b0;
        outs("nt.c1", 1'b0, 11'h020, 1'b0, 1'b1, 1'b0);
        tick();
        outs("nt.c2", 1'b0, 11'h020, 1'b0, 1'b0, 1'b0);

        // Unconditional jump: ignored.
        present(14'b100_00000001010, 1'b1, 1'b1, 1'b1);
        tick();
        ex_valid = 1'b0;
        outs("jmp", 1'b0, 11'h020, 1'b0, 1'b0, 1'b0);

        // Taken N branch with fetch stalled; a second branch mid-stall is ignored.
        rif.redirect_ready = 1'b0;
        present(14'b111_00001010101, 1'b0, 1'b0, 1'b1);
        tick();
        ex_valid = 1'b0;
        outs("stall.c0", 1'b1, 11'h055, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) present(14'b101_00011111111, 1'b1, 1'b0, 1'b0);
            else        ex_valid = 1'b0;
            tick();
            outs("stall.hold", 1'b1, 11'h055, 1'b1, 1'b0, 1'b1);
        end
        ex_valid = 1'b0;
        rif.redirect_ready = 1'b1;
        tick();
        outs("stall.hs", 1'b0, 11'h055, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        outs("stall.end", 1'b0, 11'h055, 1'b0, 1'b0, 1'b0);

        // Reset asserted during FLUSH.
        present(14'b110_00000000011, 1'b0, 1'b1, 1'b0);
        tick();
        ex_valid = 1'b0;
        tick();
        outs("rf.flush", 1'b0, 11'h003, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        outs("rf.reset", 1'b0, 11'h000, 1'b0, 1'b0, 1'b0);
        chk("rf.stat_cond",  32'(stat_cond),  32'd0);
        chk("rf.stat_taken", 32'(stat_taken), 32'd0);

        // Branch right after reset resolves normally (stats: 1 cond, 1 taken).
        present(14'b101_11111111111, 1'b1, 1'b0, 1'b0);
        tick();
        ex_valid = 1'b0;
        outs("pr.c1", 1'b1, 11'h7FF, 1'b1, 1'b0, 1'b1);
        tick();
        outs("pr.c2", 1'b0, 11'h7FF, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        outs("pr.end", 1'b0, 11'h7FF, 1'b0, 1'b0, 1'b0);

        // Taken Z (2,2); not-taken N presented on last FLUSH cycle, accepted on return to IDLE.
        present(14'b101_00100000000, 1'b1, 1'b0, 1'b0);
        tick();
        ex_valid = 1'b0;
        outs("bb.c1", 1'b1, 11'h100, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        present(14'b111_00000000001, 1'b1, 1'b1, 1'b0);
        tick();
        outs("bb.ignored", 1'b0, 11'h100, 1'b0, 1'b0, 1'b0);
        tick();
        outs("bb.accept", 1'b0, 11'h100, 1'b0, 1'b1, 1'b0);
        // Immediate not-taken C (4,2).
        present(14'b110_00000000010, 1'b1, 1'b0, 1'b1);
        tick();
        ex_valid = 1'b0;
        outs("bb.nt2", 1'b0, 11'h100, 1'b0, 1'b1, 1'b0);

        // Taken C (5,3).
        present(14'b110_01110101010, 1'b0, 1'b1, 1'b0);
        tick();
        ex_valid = 1'b0;
        outs("tc.c1", 1'b1, 11'h3AA, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        outs("tc.end", 1'b0, 11'h3AA, 1'b0, 1'b0, 1'b0);

`ifdef BRANCH_STATS_EN
        chk("stats.cond",  32'(stat_cond),  32'd5);
        chk("stats.taken", 32'(stat_taken), 32'd3);
`else
        chk("stats.cond",  32'(stat_cond),  32'd0);
        chk("stats.taken", 32'(stat_taken), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
